// File: rtl/phase_pkg.sv
// Shared constants and helpers for the phase sequencer.
package phase_pkg;

  localparam int DEFAULT_NUM_PHASES = 5;
  localparam int DEFAULT_CNT_W      = 16;
  localparam int MAX_PHASES         = 16;

  // One-hot encoding of a phase index, sized for the largest supported phase count.
  function automatic logic [MAX_PHASES-1:0] idx_to_onehot(input int unsigned idx);
    logic [MAX_PHASES-1:0] v;
    v = MAX_PHASES'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/phase_next_sel.sv
// Next-phase selector: rotating priority search from the current phase for
// the first phase not bypassed by skip_mask. Phase 0 is always eligible.
module phase_next_sel
  import phase_pkg::*;
#(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES
) (
  input  logic [NUM_PHASES-1:0] cur_phase,
  input  logic [NUM_PHASES-1:0] skip_mask,
  output logic [NUM_PHASES-1:0] next_phase
);

  localparam int IDX_W = $clog2(NUM_PHASES);

  logic [IDX_W-1:0] cur_idx;
  logic             found;

  // Encode current one-hot to binary, then search ascending with wrap.
  always_comb begin
    cur_idx    = '0;
    next_phase = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (cur_phase[i]) cur_idx = cur_idx | i[IDX_W-1:0];
    end
    for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
      int unsigned      j;
      logic [IDX_W-1:0] j_idx;
      j = 32'(cur_idx) + k;
      if (j >= NUM_PHASES) j = j - NUM_PHASES;
      j_idx = j[IDX_W-1:0];
      if (!found && ((j == 0) || !skip_mask[j_idx])) begin
        next_phase[j_idx] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Two-stage (master on posedge, slave on negedge) one-hot phase sequencer
// with skippable phases, flush, and a retired-cycle counter.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [NUM_PHASES-1:0] skip_mask,
  output logic [NUM_PHASES-1:0] phase,
  output logic [NUM_PHASES-1:0] phase_next,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  cycle_done,
  output logic [CNT_W-1:0]      retired
);

  localparam logic [MAX_PHASES-1:0] PHASE0_FULL = idx_to_onehot(0);
  localparam logic [NUM_PHASES-1:0] PHASE0      = PHASE0_FULL[NUM_PHASES-1:0];

  logic [NUM_PHASES-1:0] master;
  logic [NUM_PHASES-1:0] slave;
  logic [NUM_PHASES-1:0] sel_next;
  logic                  master_legal;

  phase_next_sel #(
    .NUM_PHASES (NUM_PHASES)
  ) u_next_sel (
    .cur_phase  (master),
    .skip_mask  (skip_mask),
    .next_phase (sel_next)
  );

  // Exactly one bit hot in the master register.
  always_comb begin
    master_legal = (master != '0) && ((master & (master - NUM_PHASES'(1))) == '0);
  end

  // Master stage and retired counter: reset > flush > illegal-correct > advance > hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      master  <= PHASE0;
      retired <= '0;
    end else if (flush || !master_legal) begin
      master <= PHASE0;
    end else if (advance) begin
      master <= sel_next;
      if (sel_next[0]) retired <= retired + CNT_W'(1);
    end
  end

  // Slave stage copies master on every falling edge; no reset needed.
  always_ff @(negedge clock) begin
    slave <= master;
  end

  // Binary index of the slave phase and wrap-pending flag.
  always_comb begin
    phase_idx = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (slave[i]) phase_idx = phase_idx | i[IDX_W-1:0];
    end
    cycle_done = master[0] & ~slave[0];
  end

  assign phase      = slave;
  assign phase_next = master;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: directed scenarios then random stimulus, against an
// integer-index reference model, on a 5-phase and an 8-phase/2-bit instance.
module tb_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       advance = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] mask_a = '0;
  logic [7:0] mask_b = '0;

  logic [4:0]  phase_a, phase_next_a;
  logic [2:0]  phase_idx_a;
  logic        cycle_done_a;
  logic [15:0] retired_a;

  logic [7:0]  phase_b, phase_next_b;
  logic [2:0]  phase_idx_b;
  logic        cycle_done_b;
  logic [1:0]  retired_b;

  int checks = 0;
  int errors = 0;

  int unsigned idx_a = 0, ret_a = 0, idx_b = 0, ret_b = 0;
  int unsigned old_a = 0, old_b = 0;
  bit          slave_valid = 1'b0;

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .advance(advance), .flush(flush),
    .skip_mask(mask_a), .phase(phase_a), .phase_next(phase_next_a),
    .phase_idx(phase_idx_a), .cycle_done(cycle_done_a), .retired(retired_a)
  );

  phase_sequencer #(.NUM_PHASES(8), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .advance(advance), .flush(flush),
    .skip_mask(mask_b), .phase(phase_b), .phase_next(phase_next_b),
    .phase_idx(phase_idx_b), .cycle_done(cycle_done_b), .retired(retired_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next phase by the stated rule: walk forward with wrap until phase 0 or a non-skipped phase.
  function automatic int unsigned model_next(input int unsigned cur, input int unsigned n,
                                             input logic [15:0] mask);
    int unsigned j;
    j = cur;
    do begin
      j = (j + 1) % n;
    end while (j != 0 && mask[j[3:0]]);
    return j;
  endfunction

  task automatic step(input logic r, input logic f, input logic a,
                      input logic [4:0] ma, input logic [7:0] mb);
    int unsigned n;
    reset = r; flush = f; advance = a; mask_a = ma; mask_b = mb;
    old_a = idx_a; old_b = idx_b;
    if (r) begin
      idx_a = 0; ret_a = 0; idx_b = 0; ret_b = 0;
    end else if (f) begin
      idx_a = 0; idx_b = 0;
    end else if (a) begin
      n = model_next(idx_a, 5, {11'b0, ma});
      if (n == 0) ret_a = (ret_a + 1) % 65536;
      idx_a = n;
      n = model_next(idx_b, 8, {8'b0, mb});
      if (n == 0) ret_b = (ret_b + 1) % 4;
      idx_b = n;
    end
    @(posedge clock); #1;
    chk("a.phase_next", 32'(phase_next_a), 32'(1) << idx_a);
    chk("a.retired",    32'(retired_a),    ret_a);
    chk("b.phase_next", 32'(phase_next_b), 32'(1) << idx_b);
    chk("b.retired",    32'(retired_b),    ret_b);
    if (slave_valid) begin
      chk("a.phase_lag",  32'(phase_a),      32'(1) << old_a);
      chk("b.phase_lag",  32'(phase_b),      32'(1) << old_b);
      chk("a.cycle_done", 32'(cycle_done_a), 32'(idx_a == 0 && old_a != 0));
      chk("b.cycle_done", 32'(cycle_done_b), 32'(idx_b == 0 && old_b != 0));
    end
    @(negedge clock); #1;
    slave_valid = 1'b1;
    chk("a.phase",      32'(phase_a),      32'(1) << idx_a);
    chk("a.phase_idx",  32'(phase_idx_a),  idx_a);
    chk("a.cycle_low",  32'(cycle_done_a), 0);
    chk("b.phase",      32'(phase_b),      32'(1) << idx_b);
    chk("b.phase_idx",  32'(phase_idx_b),  idx_b);
    chk("b.cycle_low",  32'(cycle_done_b), 0);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 5'b0, 8'b0);
    step(1, 1, 1, 5'b0, 8'b0);

    // Plain advance through all phases and wrap
    for (int i = 0; i < 6; i++) step(0, 0, 1, 5'b0, 8'b0);
    chk("a.retired_after_wrap", 32'(retired_a), 1);

    // Skip phases 1 and 3
    step(1, 0, 0, 5'b0, 8'b0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 5'b01010, 8'b0);
    chk("a.retired_skip", 32'(retired_a), 2);

    // Flush with advance at phase 3
    step(1, 0, 0, 5'b0, 8'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5'b0, 8'b0);
    step(0, 1, 1, 5'b0, 8'b0);
    chk("a.retired_flush", 32'(retired_a), 0);

    // Advance toggled 1,0,0,1 with mask changes while holding
    step(0, 0, 1, 5'b0, 8'b0);
    step(0, 0, 0, 5'b11110, 8'hFE);
    step(0, 0, 0, 5'b00110, 8'h0E);
    step(0, 0, 1, 5'b0, 8'b0);

    // All non-zero phases skipped, then reset mid-cycle
    step(1, 0, 0, 5'b0, 8'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 5'b11110, 8'hFE);
    chk("a.retired_allskip", 32'(retired_a), 4);
    step(0, 0, 1, 5'b0, 8'b0);
    step(0, 0, 1, 5'b0, 8'b0);
    step(1, 0, 1, 5'b0, 8'b0);
    chk("a.retired_midreset", 32'(retired_a), 0);

    // 8-phase instance: four full cycles wrap the 2-bit counter to 0
    for (int i = 0; i < 24; i++) step(0, 0, 1, 5'b0, 8'b0);
    chk("b.retired_3", 32'(retired_b), 3);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 5'b0, 8'b0);
    chk("b.retired_wrap", 32'(retired_b), 0);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 14) == 0),
           logic'($urandom_range(0, 3) != 0), 5'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
